// File: rtl/ex_stage_adder_if.sv
// ---------------------------------------------------------------------------
// ex_stage_adder_if
//   Bundles the operand request and the registered result of the EX-stage
//   adder/subtractor. There is no ready signal: the consumer must accept
//   every out_valid pulse.
//
//   Parameter:
//     WIDTH      operand/result bit width (legal range 2..64)
//
//   Signals:
//     in_valid   operands valid this cycle          (master -> slave)
//     sub        0 = a+b, 1 = a-b                   (master -> slave)
//     a, b       WIDTH-bit operands                 (master -> slave)
//     out_valid  result/flags valid                 (slave -> master)
//     result     sum or difference mod 2^WIDTH      (slave -> master)
//     carry      unsigned carry-out / no-borrow     (slave -> master)
//     overflow   signed overflow                    (slave -> master)
//     zero       result == 0                        (slave -> master)
//     negative   result MSB                         (slave -> master)
//
//   Modports:
//     master     the pipeline side issuing operations
//     slave      the adder itself
// ---------------------------------------------------------------------------
interface ex_stage_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, sub, a, b,
    input  out_valid, result, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, sub, a, b,
    output out_valid, result, carry, overflow, zero, negative
  );

endinterface

// File: rtl/ex_stage_adder.sv
// ---------------------------------------------------------------------------
// ex_stage_adder
//   Registered two's-complement adder/subtractor for the EX stage of the MIPS
//   pipeline (branch-target and address computation). Operands are sampled on
//   a rising clk edge when in_valid is high; result and flags are presented
//   one cycle later together with out_valid. Signed and unsigned users share
//   one datapath and pick whichever flags matter to them.
//
//   Parameter:
//     WIDTH   operand/result bit width (legal range 2..64)
//
//   Ports:
//     clk     rising-edge clock, sole clock domain
//     rst_n   asynchronous active-low reset
//     bus     ex_stage_adder_if.slave: in_valid, sub, a, b in;
//             out_valid, result, carry, overflow, zero, negative out
// ---------------------------------------------------------------------------
module ex_stage_adder #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  ex_stage_adder_if.slave     bus
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry_next;
  logic             overflow_next;
  logic             zero_next;
  logic             negative_next;

  // Subtraction is a + ~b + 1, so the carry-out doubles as the unsigned
  // "no borrow" indication. The sum is formed one bit wider to expose it.
  // zero/negative come from this cycle's sum, so they always describe the
  // result they are registered alongside.
  always_comb begin
    bx            = bus.sub ? ~bus.b : bus.b;
    sum_ext       = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, bus.sub};
    sum           = sum_ext[WIDTH-1:0];
    carry_next    = sum_ext[WIDTH];
    // Signed overflow: both addends share a sign and the sum's sign differs.
    overflow_next = (bus.a[WIDTH-1] == bx[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.a[WIDTH-1]);
    zero_next     = (sum == '0);
    negative_next = sum[WIDTH-1];
  end

  // out_valid follows in_valid every edge. The result/flag registers load
  // only when in_valid is high, so they hold across idle cycles and unknown
  // operands presented while idle never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.negative  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result    <= sum;
        bus.carry     <= carry_next;
        bus.overflow  <= overflow_next;
        bus.zero      <= zero_next;
        bus.negative  <= negative_next;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_adder.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_adder
//   Self-checking bench for ex_stage_adder (WIDTH = 32). Expected outputs come
//   from an arithmetic reference model that works on 64-bit integers and
//   decides carry/overflow from the true mathematical result.
// ---------------------------------------------------------------------------
module tb_ex_stage_adder;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    logic             z;
    logic             n;
  } obs_t;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  obs_t held;
  obs_t expected;

  ex_stage_adder_if #(.WIDTH(WIDTH)) bus ();

  ex_stage_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot of every DUT output, packed in the same order as obs_t.
  function automatic obs_t observed();
    return {bus.out_valid, bus.result, bus.carry, bus.overflow, bus.zero, bus.negative};
  endfunction

  // Reference model: compute the exact signed and unsigned results as 64-bit
  // integers, then derive carry (no unsigned wrap / no borrow) and overflow
  // (signed result out of the 32-bit range) from them.
  function automatic obs_t model(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    obs_t   m;
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint full_s;
    logic [63:0] bits;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (!s) begin
      m.c    = (ua + ub) > 64'sd4294967295;
      full_s = sa + sb;
    end else begin
      m.c    = (ua >= ub);
      full_s = sa - sb;
    end
    bits = full_s;
    m.v  = 1'b1;
    m.r  = bits[31:0];
    m.o  = (full_s > 64'sd2147483647) || (full_s < -64'sd2147483648);
    m.z  = (m.r == 32'd0);
    m.n  = m.r[31];
    return m;
  endfunction

  // Drives one cycle of input at the falling edge, waits for the capturing
  // rising edge and settles, and updates what the outputs should now show.
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.in_valid = v;
    bus.sub      = s;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    if (v) held = model(s, a, b);
    expected   = held;
    expected.v = v;
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    logic [WIDTH-1:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  // Asynchronous reset with no clock edge involved, then outputs pinned at
  // zero across edges even while operands are offered.
  task automatic test_reset();
    obs_t zeros;
    zeros = '0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.sub      = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== zeros) begin
      failures++;
      $display("[TB] FAIL reset_async actual=%h required=%h", observed(), zeros);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h1234_5678;
      bus.b        = 32'h0000_0001;
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== zeros) begin
        failures++;
        $display("[TB] FAIL reset_held cycle=%0d actual=%h required=%h", i, observed(), zeros);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    held         = '0;
  endtask

  // Directed vectors with hand-worked expected values.
  task automatic test_directed();
    typedef struct packed {
      logic             s;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      obs_t             e;
    } vec_t;
    vec_t vecs [10];
    vecs[0] = '{1'b0, 32'd10,         32'd20,         '{1'b1, 32'h0000_001E, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{1'b0, 32'd15,         32'hFFFF_FFFB,  '{1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{1'b1, 32'd15,         32'd5,          '{1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 32'hFFFF_FFF6,  32'hFFFF_FFEC,  '{1'b1, 32'hFFFF_FFE2, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{1'b0, 32'd0,          32'd50,         '{1'b1, 32'h0000_0032, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{1'b1, 32'd5,          32'd5,          '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[6] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'd1,          '{1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[9] = '{1'b1, 32'd0,          32'd1,          '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].s, vecs[i].a, vecs[i].b);
      checks++;
      if (observed() !== vecs[i].e) begin
        failures++;
        $display("[TB] FAIL directed_%0d actual=%h required=%h", i, observed(), vecs[i].e);
      end
    end
  endtask

  // Four consecutive operations: each must come out on the following edge.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom());
      checks++;
      if (observed() !== expected) begin
        failures++;
        $display("[TB] FAIL back_to_back_%0d actual=%h required=%h", i, observed(), expected);
      end
    end
  endtask

  // Idle cycles with unknown operands: out_valid drops, result/flags hold.
  task automatic test_idle_gap();
    applyStimulus(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0007);
    checks++;
    if (observed() !== expected) begin
      failures++;
      $display("[TB] FAIL idle_setup actual=%h required=%h", observed(), expected);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'bx, 'x, 'x);
      checks++;
      if (observed() !== expected) begin
        failures++;
        $display("[TB] FAIL idle_gap_%0d actual=%h required=%h", i, observed(), expected);
      end
    end
  endtask

  // Random mix of valid and idle cycles, biased toward corner operands.
  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    pick_operand(), pick_operand());
      checks++;
      if (observed() !== expected) begin
        failures++;
        $display("[TB] FAIL random_%0d actual=%h required=%h", i, observed(), expected);
      end
    end
  endtask

  // Reset between clock edges with an operation in flight: outputs clear at
  // once, nothing stale appears after release, next operation is normal.
  task automatic test_reset_midstream();
    obs_t zeros;
    zeros = '0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200);
    checks++;
    if (observed() !== expected) begin
      failures++;
      $display("[TB] FAIL midreset_setup actual=%h required=%h", observed(), expected);
    end
    bus.in_valid = 1'b1;
    bus.sub      = 1'b0;
    bus.a        = 32'h0000_0055;
    bus.b        = 32'h0000_0011;
    #2;
    rst_n = 1'b0;
    #1;
    held = '0;
    checks++;
    if (observed() !== zeros) begin
      failures++;
      $display("[TB] FAIL midreset_immediate actual=%h required=%h", observed(), zeros);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== zeros) begin
      failures++;
      $display("[TB] FAIL midreset_held actual=%h required=%h", observed(), zeros);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== zeros) begin
      failures++;
      $display("[TB] FAIL midreset_no_stale actual=%h required=%h", observed(), zeros);
    end
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0002);
    checks++;
    if (observed() !== expected) begin
      failures++;
      $display("[TB] FAIL midreset_first_op actual=%h required=%h", observed(), expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    held     = '0;
    expected = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_idle_gap();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
